vx_csr_lane_splitter: RTL and testbench

- Sits directly upstream of the CSR unit, between the SFU dispatch path and the CSR unit's execute input.
- Accepts one full-warp CSR instruction (THREAD_CNT lanes) and emits it as THREAD_CNT/NUM_LANES sequential packets of NUM_LANES lanes each.
- Each packet carries pid, sop and eop, which the CSR unit uses for per-packet thread IDs and warp unlock.
- Holds one instruction in a capture register; the next instruction may be captured on the cycle the last packet of the current one is accepted.

---
 rtl/vx_csr_lane_splitter.sv | 176 +++++++++++++++++
 tb/tb_vx_csr_lane_splitter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_csr_lane_splitter.sv
// Splits a full-warp CSR instruction into THREAD_CNT/NUM_LANES sequential lane packets.
// Optional macro CSR_SPLIT_SKIP_EMPTY_EN: skip packets whose tmask slice is all-zero.
module vx_csr_lane_splitter #(
    parameter int NUM_LANES    = 1,
    parameter int THREAD_CNT   = 4,
    parameter int XLEN         = 32,
    parameter int UUID_WIDTH   = 44,
    parameter int NW_WIDTH     = 2,
    parameter int INST_OP_BITS = 4,
    parameter int NR_BITS      = 5,
    localparam int NUM_PKTS    = THREAD_CNT / NUM_LANES,
    localparam int PID_BITS    = $clog2(NUM_PKTS),
    localparam int PID_WIDTH   = (PID_BITS > 0) ? PID_BITS : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [UUID_WIDTH-1:0]        in_uuid,
    input  logic [NW_WIDTH-1:0]          in_wid,
    input  logic [THREAD_CNT-1:0]        in_tmask,
    input  logic [XLEN-1:0]              in_PC,
    input  logic [INST_OP_BITS-1:0]      in_op_type,
    input  logic [XLEN-1:0]              in_imm,
    input  logic                         in_use_imm,
    input  logic [NR_BITS-1:0]           in_rd,
    input  logic                         in_wb,
    input  logic [THREAD_CNT*XLEN-1:0]   in_rs1_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [UUID_WIDTH-1:0]        out_uuid,
    output logic [NW_WIDTH-1:0]          out_wid,
    output logic [NUM_LANES-1:0]         out_tmask,
    output logic [XLEN-1:0]              out_PC,
    output logic [INST_OP_BITS-1:0]      out_op_type,
    output logic [XLEN-1:0]              out_imm,
    output logic                         out_use_imm,
    output logic [NR_BITS-1:0]           out_rd,
    output logic                         out_wb,
    output logic [NUM_LANES*XLEN-1:0]    out_rs1_data,
    output logic [PID_WIDTH-1:0]         out_pid,
    output logic                         out_sop,
    output logic                         out_eop
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                       r_state;
    logic [PID_WIDTH-1:0]         r_pid;
    logic                         r_sop;
    logic [UUID_WIDTH-1:0]        r_uuid;
    logic [NW_WIDTH-1:0]          r_wid;
    logic [THREAD_CNT-1:0]        r_tmask;
    logic [XLEN-1:0]              r_PC;
    logic [INST_OP_BITS-1:0]      r_op_type;
    logic [XLEN-1:0]              r_imm;
    logic                         r_use_imm;
    logic [NR_BITS-1:0]           r_rd;
    logic                         r_wb;
    logic [THREAD_CNT*XLEN-1:0]   r_rs1;

    logic                         w_in_fire;
    logic                         w_out_fire;
    logic                         w_has_next;
    logic [PID_WIDTH-1:0]         w_first_pid;
    logic [PID_WIDTH-1:0]         w_next_pid;
    logic [NUM_LANES-1:0]         w_tmask_sl;
    logic [NUM_LANES*XLEN-1:0]    w_rs1_sl;

    assign out_valid  = (r_state == S_BUSY);
    assign out_eop    = !w_has_next;
    assign w_out_fire = out_valid && out_ready;
    assign in_ready   = !reset && ((r_state == S_IDLE) || (w_out_fire && out_eop));
    assign w_in_fire  = in_valid && in_ready;

`ifdef CSR_SPLIT_SKIP_EMPTY_EN
    logic [NUM_PKTS-1:0] w_in_nz;
    logic [NUM_PKTS-1:0] w_r_nz;
    logic                w_found_first;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PKTS; p++) begin
            w_in_nz[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
            w_r_nz[p]  = |r_tmask[p*NUM_LANES +: NUM_LANES];
        end
    end

    // Lowest non-zero slice; an all-zero mask falls back to a single pid-0 packet.
    always_comb begin
        w_first_pid   = '0;
        w_found_first = 1'b0;
        for (int unsigned p = 0; p < NUM_PKTS; p++) begin
            if (!w_found_first && w_in_nz[p]) begin
                w_first_pid   = PID_WIDTH'(p);
                w_found_first = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_pid = r_pid;
        w_has_next = 1'b0;
        for (int unsigned p = 0; p < NUM_PKTS; p++) begin
            if (!w_has_next && (PID_WIDTH'(p) > r_pid) && w_r_nz[p]) begin
                w_next_pid = PID_WIDTH'(p);
                w_has_next = 1'b1;
            end
        end
    end
`else
    assign w_first_pid = '0;
    assign w_next_pid  = r_pid + PID_WIDTH'(1);
    assign w_has_next  = (r_pid != PID_WIDTH'(NUM_PKTS - 1));
`endif

    always_comb begin
        w_tmask_sl = '0;
        w_rs1_sl   = '0;
        for (int unsigned p = 0; p < NUM_PKTS; p++) begin
            if (r_pid == PID_WIDTH'(p)) begin
                w_tmask_sl = r_tmask[p*NUM_LANES +: NUM_LANES];
                w_rs1_sl   = r_rs1[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
            end
        end
    end

    // A capture while BUSY only happens on the eop fire, so it takes priority over advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pid   <= '0;
            r_sop   <= 1'b0;
        end else if (w_in_fire) begin
            r_state <= S_BUSY;
            r_pid   <= w_first_pid;
            r_sop   <= 1'b1;
        end else if (w_out_fire) begin
            if (out_eop) begin
                r_state <= S_IDLE;
                r_sop   <= 1'b0;
            end else begin
                r_pid   <= w_next_pid;
                r_sop   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_uuid    <= in_uuid;
            r_wid     <= in_wid;
            r_tmask   <= in_tmask;
            r_PC      <= in_PC;
            r_op_type <= in_op_type;
            r_imm     <= in_imm;
            r_use_imm <= in_use_imm;
            r_rd      <= in_rd;
            r_wb      <= in_wb;
            r_rs1     <= in_rs1_data;
        end
    end

    assign out_uuid     = r_uuid;
    assign out_wid      = r_wid;
    assign out_tmask    = w_tmask_sl;
    assign out_PC       = r_PC;
    assign out_op_type  = r_op_type;
    assign out_imm      = r_imm;
    assign out_use_imm  = r_use_imm;
    assign out_rd       = r_rd;
    assign out_wb       = r_wb;
    assign out_rs1_data = w_rs1_sl;
    assign out_pid      = r_pid;
    assign out_sop      = r_sop;

endmodule

// File: tb/tb_vx_csr_lane_splitter.sv
// Directed bench for vx_csr_lane_splitter at THREAD_CNT=8, NUM_LANES=2 (four packets per warp).
module tb_vx_csr_lane_splitter;

    localparam int TC = 8;
    localparam int NL = 2;
    localparam int XL = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [43:0]       in_uuid;
    logic [1:0]        in_wid;
    logic [TC-1:0]     in_tmask;
    logic [XL-1:0]     in_PC;
    logic [3:0]        in_op_type;
    logic [XL-1:0]     in_imm;
    logic              in_use_imm;
    logic [4:0]        in_rd;
    logic              in_wb;
    logic [TC*XL-1:0]  in_rs1_data;
    logic              out_valid;
    logic              out_ready;
    logic [43:0]       out_uuid;
    logic [1:0]        out_wid;
    logic [NL-1:0]     out_tmask;
    logic [XL-1:0]     out_PC;
    logic [3:0]        out_op_type;
    logic [XL-1:0]     out_imm;
    logic              out_use_imm;
    logic [4:0]        out_rd;
    logic              out_wb;
    logic [NL*XL-1:0]  out_rs1_data;
    logic [1:0]        out_pid;
    logic              out_sop;
    logic              out_eop;

    vx_csr_lane_splitter #(
        .NUM_LANES(NL), .THREAD_CNT(TC), .XLEN(XL), .UUID_WIDTH(44),
        .NW_WIDTH(2), .INST_OP_BITS(4), .NR_BITS(5)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC),
        .in_op_type(in_op_type), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rd(in_rd), .in_wb(in_wb), .in_rs1_data(in_rs1_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid),
        .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC),
        .out_op_type(out_op_type), .out_imm(out_imm), .out_use_imm(out_use_imm),
        .out_rd(out_rd), .out_wb(out_wb), .out_rs1_data(out_rs1_data),
        .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tmask;
        logic [1:0] wid;
        int         npkts;
        logic [7:0] pids;   // pid of k-th emitted packet at [2k+1:2k]
    } vec_t;

    vec_t        vecs[6];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cur_rs1[TC];
    logic [7:0]  cur_tm;
    logic [1:0]  cur_wid;
    logic [31:0] cur_pc;
    logic [7:0]  cur_tag;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_instr(input logic [7:0] tm, input logic [1:0] wid, input logic [7:0] tag);
        cur_tm  = tm;
        cur_wid = wid;
        cur_tag = tag;
        cur_pc  = 32'h8000_0000 + {24'h0, tag};
        for (int t = 0; t < TC; t++) begin
            cur_rs1[t]            = {tag, 16'h0, 8'(t + 1)};
            in_rs1_data[t*XL +: XL] = cur_rs1[t];
        end
        in_tmask   = tm;
        in_wid     = wid;
        in_PC      = cur_pc;
        in_uuid    = {36'h0, tag};
        in_op_type = tag[3:0];
        in_imm     = {24'h0, ~tag};
        in_use_imm = tag[0];
        in_rd      = tag[4:0];
        in_wb      = tag[1];
        in_valid   = 1'b1;
    endtask

    task automatic check_pkt(input string name, input logic [1:0] pid, input logic sop, input logic eop);
        chk({name, "_valid"}, 64'(out_valid), 64'(1'b1));
        chk({name, "_pid"},   64'(out_pid), 64'(pid));
        chk({name, "_sop"},   64'(out_sop), 64'(sop));
        chk({name, "_eop"},   64'(out_eop), 64'(eop));
        chk({name, "_tmask"}, 64'(out_tmask), 64'(cur_tm[pid*2 +: 2]));
        chk({name, "_rs1"},   64'(out_rs1_data), {cur_rs1[pid*2+1], cur_rs1[pid*2]});
        chk({name, "_wid"},   64'(out_wid), 64'(cur_wid));
        chk({name, "_pc"},    64'(out_PC), 64'(cur_pc));
        chk({name, "_flds"},  {out_uuid[7:0], out_op_type, out_imm[7:0], out_use_imm, out_rd, out_wb},
                              {cur_tag, cur_tag[3:0], ~cur_tag, cur_tag[0], cur_tag[4:0], cur_tag[1]});
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(out_valid), 64'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_uuid = '0; in_wid = '0; in_tmask = '0; in_PC = '0; in_op_type = '0;
        in_imm = '0; in_use_imm = 1'b0; in_rd = '0; in_wb = 1'b0; in_rs1_data = '0;

`ifdef CSR_SPLIT_SKIP_EMPTY_EN
        vecs[0] = '{8'hFF, 2'd1, 4, 8'hE4};
        vecs[1] = '{8'h30, 2'd2, 1, 8'h02};
        vecs[2] = '{8'h00, 2'd3, 1, 8'h00};
        vecs[3] = '{8'h81, 2'd0, 2, 8'h0C};
        vecs[4] = '{8'h0C, 2'd1, 1, 8'h01};
        vecs[5] = '{8'h44, 2'd2, 2, 8'h0D};
`else
        vecs[0] = '{8'hFF, 2'd1, 4, 8'hE4};
        vecs[1] = '{8'h30, 2'd2, 4, 8'hE4};
        vecs[2] = '{8'h00, 2'd3, 4, 8'hE4};
        vecs[3] = '{8'h81, 2'd0, 4, 8'hE4};
        vecs[4] = '{8'h0C, 2'd1, 4, 8'hE4};
        vecs[5] = '{8'h44, 2'd2, 4, 8'hE4};
`endif

        // Reset state
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_in_ready",  64'(in_ready),  64'(1'b0));
        reset = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("post_rst_valid",    64'(out_valid), 64'(1'b0));

        // Table-driven instructions, out_ready held high
        for (int v = 0; v < 6; v++) begin
            load_instr(vecs[v].tmask, vecs[v].wid, 8'(16 + v));
            chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'(1'b1));
            step();
            in_valid = 1'b0;
            for (int k = 0; k < vecs[v].npkts; k++) begin
                check_pkt($sformatf("v%0d_k%0d", v, k), vecs[v].pids[2*k +: 2],
                          (k == 0), (k == vecs[v].npkts - 1));
                step();
            end
            chk($sformatf("v%0d_idle", v), 64'(out_valid), 64'(1'b0));
        end

        // Stall on pid0 for three cycles
        load_instr(8'hFF, 2'd1, 8'h40);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_pkt($sformatf("stall_c%0d", c), 2'd0, 1'b1, 1'b0);
            chk($sformatf("stall_c%0d_in_ready", c), 64'(in_ready), 64'(1'b0));
            step();
        end
        out_ready = 1'b1;
        check_pkt("stall_rel", 2'd0, 1'b1, 1'b0);
        step();
        check_pkt("stall_resume", 2'd1, 1'b0, 1'b0);
        drain();

        // Back-to-back: new instruction captured on the eop fire
        load_instr(8'hFF, 2'd1, 8'h50);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_pkt($sformatf("b2b_a%0d", k), 2'(k), (k == 0), 1'b0);
            step();
        end
        check_pkt("b2b_last", 2'd3, 1'b0, 1'b1);
        load_instr(8'hFF, 2'd2, 8'h60);
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'(1'b1));
        step();
        in_valid = 1'b0;
        check_pkt("b2b_new", 2'd0, 1'b1, 1'b0);
        drain();

        // Reset in the middle of an instruction
        load_instr(8'hFF, 2'd3, 8'h70);
        step();
        in_valid = 1'b0;
        step();
        check_pkt("mid_pid1", 2'd1, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk("mid_rst_valid",    64'(out_valid), 64'(1'b0));
        chk("mid_rst_in_ready", 64'(in_ready),  64'(1'b0));
        reset = 1'b0;
        step();
        chk("mid_rst_idle", 64'(out_valid), 64'(1'b0));
        load_instr(8'hFF, 2'd0, 8'h80);
        chk("mid_rst_ready", 64'(in_ready), 64'(1'b1));
        step();
        in_valid = 1'b0;
        check_pkt("mid_restart", 2'd0, 1'b1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
